uart_div_calc: RTL and testbench

UART_DIV_CALC -- requirements
Module: uart_div_calc

---
 rtl/uart_calc_pkg.sv | 45 ++++
 rtl/seq_divider.sv | 75 +++++++
 rtl/uart_div_calc.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_div_calc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_calc_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_calc_pkg: state encoding, ASCII constants and message text for the   |
// | UART decimal divide calculator.                     Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none
package uart_calc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_INIT    = 3'd0;
    localparam state_t S_PROMPT1 = 3'd1;
    localparam state_t S_READ1   = 3'd2;
    localparam state_t S_PROMPT2 = 3'd3;
    localparam state_t S_READ2   = 3'd4;
    localparam state_t S_DIVIDE  = 3'd5;
    localparam state_t S_REPLY   = 3'd6;
    localparam state_t S_ERR     = 3'd7;

    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_LF    = 8'h0A;
    localparam logic [7:0] C_ZERO  = 8'h30;
    localparam logic [7:0] C_NINE  = 8'h39;
    localparam logic [7:0] C_SEVEN = 8'h37;

    localparam int C_P1_LEN   = 34;
    localparam int C_P2_LEN   = 35;
    localparam int C_QHDR_LEN = 29;
    localparam int C_RHDR_LEN = 15;
    localparam int C_TAIL_LEN = 3;
    localparam int C_ERR_LEN  = 26;

    // Text is stored first-byte-in-MSBs so byte k sits at [8*(LEN-1-k) +: 8].
    localparam logic [8*C_P1_LEN-1:0]   C_P1_TXT   = {C_CR, C_LF, "Enter the first decimal number: "};
    localparam logic [8*C_P2_LEN-1:0]   C_P2_TXT   = {C_CR, C_LF, "Enter the second decimal number: "};
    localparam logic [8*C_QHDR_LEN-1:0] C_QHDR_TXT = {C_CR, C_LF, "The integer quotient is: 0x"};
    localparam logic [8*C_RHDR_LEN-1:0] C_RHDR_TXT = ", remainder: 0x";
    localparam logic [8*C_TAIL_LEN-1:0] C_TAIL_TXT = {".", C_CR, C_LF};
    localparam logic [8*C_ERR_LEN-1:0]  C_ERR_TXT  = {C_CR, C_LF, "Error: divide by zero.", C_CR, C_LF};

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (C_ZERO + {4'd0, n}) : (C_SEVEN + {4'd0, n});
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------------+
// | seq_divider: restoring shift-subtract divider, one quotient bit per clock.|
// |                                                     Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = (shifted >= {1'b0, dvs_q});
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // A non-fitting trial leaves shifted < divisor, so it fits in WIDTH bits.
            rem_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], fits};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done      = run_q && (cnt_q == CNT_W'(WIDTH-1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/uart_div_calc.sv
// +----------------------------------------------------------------------------+
// | uart_div_calc: UART-driven calculator that reads two decimal operands and |
// | replies with their hex quotient (and remainder).    Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none
module uart_div_calc
    import uart_calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5,
    parameter int REM_EN     = 1,
    parameter int INIT_DELAY = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       err_div0
);

    localparam int HEX_N     = WIDTH / 4;
    localparam int Q_END     = C_QHDR_LEN + HEX_N;
    localparam int R_HDR_END = Q_END + ((REM_EN != 0) ? C_RHDR_LEN : 0);
    localparam int R_END     = R_HDR_END + ((REM_EN != 0) ? HEX_N : 0);
    localparam int REPLY_LEN = R_END + C_TAIL_LEN;
    localparam int DLY_W     = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int CNT_W     = $clog2(MAX_DIGITS + 1);
    localparam logic [WIDTH+3:0] C_TEN = (WIDTH+4)'(10);

    state_t           state_q, state_d;
    logic [6:0]       idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       echo_q, echo_d;
    logic             echo_full_q, echo_full_d;
    logic             enter_pend_q, enter_pend_d;
    logic             err_q, err_d;

    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic [7:0]       msg_byte;
    logic             msg_last;
    int               msg_i;
    logic             tx_fire, rx_digit, rx_enter;
    logic [WIDTH-1:0] cur_op, new_op;
    logic [WIDTH+3:0] acc_ext;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (op_a_q),
        .divisor   (op_b_q),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Message byte for the current index; the index only moves on a handshake.
    always_comb begin
        msg_byte = 8'h00;
        msg_last = 1'b0;
        msg_i    = int'(idx_q);
        case (state_q)
            S_PROMPT1: begin
                msg_byte = C_P1_TXT[8*(C_P1_LEN-1-msg_i) +: 8];
                msg_last = (idx_q == 7'(C_P1_LEN-1));
            end
            S_PROMPT2: begin
                msg_byte = C_P2_TXT[8*(C_P2_LEN-1-msg_i) +: 8];
                msg_last = (idx_q == 7'(C_P2_LEN-1));
            end
            S_ERR: begin
                msg_byte = C_ERR_TXT[8*(C_ERR_LEN-1-msg_i) +: 8];
                msg_last = (idx_q == 7'(C_ERR_LEN-1));
            end
            S_REPLY: begin
                msg_last = (idx_q == 7'(REPLY_LEN-1));
                if (msg_i < C_QHDR_LEN) begin
                    msg_byte = C_QHDR_TXT[8*(C_QHDR_LEN-1-msg_i) +: 8];
                end else if (msg_i < Q_END) begin
                    msg_byte = hex_ascii(div_quo[4*(HEX_N-1-(msg_i-C_QHDR_LEN)) +: 4]);
                end else if (msg_i < R_HDR_END) begin
                    msg_byte = C_RHDR_TXT[8*(C_RHDR_LEN-1-(msg_i-Q_END)) +: 8];
                end else if (msg_i < R_END) begin
                    msg_byte = hex_ascii(div_rem[4*(HEX_N-1-(msg_i-R_HDR_END)) +: 4]);
                end else begin
                    msg_byte = C_TAIL_TXT[8*(C_TAIL_LEN-1-(msg_i-R_END)) +: 8];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        case (state_q)
            S_READ1, S_READ2: begin
                tx_valid = echo_full_q;
                tx_byte  = echo_full_q ? echo_q : 8'h00;
            end
            S_PROMPT1, S_PROMPT2, S_REPLY, S_ERR: begin
                tx_valid = 1'b1;
                tx_byte  = msg_byte;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dly_d        = dly_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        cnt_d        = cnt_q;
        echo_d       = echo_q;
        echo_full_d  = echo_full_q;
        enter_pend_d = enter_pend_q;
        err_d        = err_q;
        div_start    = 1'b0;

        tx_fire  = tx_valid && tx_ready;
        rx_digit = rx_valid && (rx_byte >= C_ZERO) && (rx_byte <= C_NINE);
        rx_enter = rx_valid && (rx_byte == C_CR);
        cur_op   = (state_q == S_READ2) ? op_b_q : op_a_q;
        acc_ext  = ({4'd0, cur_op} * C_TEN) + {{WIDTH{1'b0}}, rx_byte[3:0]};
        new_op   = (|acc_ext[WIDTH+3:WIDTH]) ? {WIDTH{1'b1}} : acc_ext[WIDTH-1:0];

        case (state_q)
            S_INIT: begin
                if (dly_q == DLY_W'(INIT_DELAY-1)) begin
                    state_d = S_PROMPT1;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_PROMPT1, S_PROMPT2, S_REPLY, S_ERR: begin
                if (tx_fire) begin
                    if (msg_last) begin
                        idx_d = '0;
                        case (state_q)
                            S_PROMPT1: state_d = S_READ1;
                            S_PROMPT2: state_d = S_READ2;
                            default:   state_d = S_PROMPT1;
                        endcase
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            S_READ1, S_READ2: begin
                if (tx_fire) begin
                    echo_full_d = 1'b0;
                end
                if (rx_digit && (cnt_q < CNT_W'(MAX_DIGITS)) && !echo_full_q) begin
                    if (state_q == S_READ1) begin
                        op_a_d = new_op;
                    end else begin
                        op_b_d = new_op;
                    end
                    cnt_d       = cnt_q + CNT_W'(1);
                    echo_d      = rx_byte;
                    echo_full_d = 1'b1;
                end
                if (rx_enter) begin
                    enter_pend_d = 1'b1;
                end
                // Enter waits in enter_pend until the last echoed digit has gone out.
                if ((enter_pend_q || rx_enter) && !echo_full_q) begin
                    enter_pend_d = 1'b0;
                    cnt_d        = '0;
                    if (state_q == S_READ1) begin
                        state_d = S_PROMPT2;
                    end else begin
                        state_d   = S_DIVIDE;
                        div_start = (op_b_q != '0);
                    end
                end
            end
            S_DIVIDE: begin
                if (op_b_q == '0) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (div_done) begin
                    state_d = S_REPLY;
                end
            end
            default: ;
        endcase

        if ((state_d == S_PROMPT1) && (state_q != S_PROMPT1)) begin
            op_a_d = '0;
            op_b_d = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            idx_q        <= '0;
            dly_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            echo_q       <= '0;
            echo_full_q  <= 1'b0;
            enter_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dly_q        <= dly_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            cnt_q        <= cnt_d;
            echo_q       <= echo_d;
            echo_full_q  <= echo_full_d;
            enter_pend_q <= enter_pend_d;
            err_q        <= err_d;
        end
    end

    assign busy     = !((state_q == S_READ1) || (state_q == S_READ2));
    assign err_div0 = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_div_calc.sv
// +----------------------------------------------------------------------------+
// | tb_uart_div_calc: directed vector bench for the UART divide calculator.   |
// |                                                     Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none
module tb_uart_div_calc;

    localparam int INIT_DELAY = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       busy;
    logic       err_div0;

    always #5 clk = ~clk;

    uart_div_calc #(
        .WIDTH      (16),
        .MAX_DIGITS (5),
        .REM_EN     (1),
        .INIT_DELAY (INIT_DELAY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .busy     (busy),
        .err_div0 (err_div0)
    );

    typedef struct {
        string a;
        string b;
        string ea;
        string eb;
        bit    div0;
        string q;
        string r;
    } vec_t;

    int    n_vec = 0;
    int    n_bad = 0;
    string cap = "";
    int    quiet = 0;
    bit    saw_err = 1'b0;
    string crlf, p1_txt, p2_txt, err_txt;
    vec_t  vecs[11];

    // Every transferred byte, plus a count of cycles that are busy yet silent.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) cap = $sformatf("%s%c", cap, tx_byte);
            if (busy && !tx_valid) quiet++;
            if (err_div0) saw_err = 1'b1;
        end
    end

    function automatic vec_t mk(input string a, input string b, input string ea,
                                input string eb, input bit d0, input string q, input string r);
        vec_t v;
        v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.div0 = d0; v.q = q; v.r = r;
        return v;
    endfunction

    function automatic string printable(input string s);
        string o = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D) o = {o, "~"};
            else if (s[i] == 8'h0A) o = {o, "|"};
            else o = $sformatf("%s%c", o, s[i]);
        end
        return o;
    endfunction

    function automatic string reply(input string q, input string r);
        return {crlf, "The integer quotient is: 0x", q, ", remainder: 0x", r, ".", crlf};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\", required \"%s\"", name, printable(got), printable(exp));
        end
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string name);
        int k = 0;
        while (busy !== lvl && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (busy !== lvl) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout %s: busy=%b, required %b", name, busy, lvl);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_line(input string s, input bit wait_done, input string name);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0D);
        if (wait_done) begin
            wait_busy(1'b1, 500, name);
            wait_busy(1'b0, 500, name);
        end
    endtask

    task automatic reset_and_init(input string tag);
        int k = 0;
        rst = 1'b1;
        #1;
        check({tag, " rst tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, " rst tx_byte"},  32'(tx_byte),  32'd0);
        check({tag, " rst busy"},     32'(busy),     32'd1);
        check({tag, " rst err_div0"}, 32'(err_div0), 32'd0);
        repeat (3) @(posedge clk); #1;
        quiet = 0;
        cap   = "";
        rst   = 1'b0;
        while (!tx_valid && k < INIT_DELAY + 50) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, " init delay"}, 32'(quiet), 32'(INIT_DELAY));
        wait_busy(1'b0, 500, {tag, " first prompt"});
        check_str({tag, " first prompt"}, cap, p1_txt);
    endtask

    task automatic run_vec(input int idx);
        string exp;
        cap = ""; quiet = 0; saw_err = 1'b0;
        send_line(vecs[idx].a, 1'b1, $sformatf("vec%0d a", idx));
        send_line(vecs[idx].b, 1'b1, $sformatf("vec%0d b", idx));
        exp = {vecs[idx].ea, p2_txt, vecs[idx].eb,
               vecs[idx].div0 ? err_txt : reply(vecs[idx].q, vecs[idx].r), p1_txt};
        check_str($sformatf("vec%0d output", idx), cap, exp);
        check($sformatf("vec%0d divide cycles", idx), 32'(quiet), vecs[idx].div0 ? 32'd1 : 32'd16);
        check($sformatf("vec%0d err seen", idx), 32'(saw_err), 32'(vecs[idx].div0));
        check($sformatf("vec%0d err cleared", idx), 32'(err_div0), 32'd0);
    endtask

    initial begin
        logic [7:0] held_b;
        logic       held_v;
        bit         stable;

        crlf    = $sformatf("%c%c", 8'h0D, 8'h0A);
        p1_txt  = {crlf, "Enter the first decimal number: "};
        p2_txt  = {crlf, "Enter the second decimal number: "};
        err_txt = {crlf, "Error: divide by zero.", crlf};

        vecs[0]  = mk("100",     "7",     "100",   "7",     1'b0, "000E", "0002");
        vecs[1]  = mk("65535",   "1",     "65535", "1",     1'b0, "FFFF", "0000");
        vecs[2]  = mk("99999",   "2",     "99999", "2",     1'b0, "7FFF", "0001");
        vecs[3]  = mk("42",      "0",     "42",    "0",     1'b1, "",     "");
        vecs[4]  = mk("1234567", "1000",  "12345", "1000",  1'b0, "000C", "0159");
        vecs[5]  = mk("a1-2",    "5",     "12",    "5",     1'b0, "0002", "0002");
        vecs[6]  = mk("",        "9",     "",      "9",     1'b0, "0000", "0000");
        vecs[7]  = mk("7",       "100",   "7",     "100",   1'b0, "0000", "0007");
        vecs[8]  = mk("255",     "16",    "255",   "16",    1'b0, "000F", "000F");
        vecs[9]  = mk("60000",   "7",     "60000", "7",     1'b0, "217B", "0003");
        vecs[10] = mk("40000",   "40000", "40000", "40000", 1'b0, "0001", "0000");

        #2;
        reset_and_init("power-up");

        for (int i = 0; i < 11; i++) run_vec(i);

        // Back-pressure in the middle of the reply.
        cap = "";
        send_line("100", 1'b1, "stall a");
        send_line("7", 1'b0, "stall b");
        repeat (25) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        held_b = tx_byte;
        held_v = tx_valid;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx_byte !== held_b || tx_valid !== held_v) stable = 1'b0;
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        check("stall tx_valid held", 32'(held_v), 32'd1);
        check("stall outputs stable", 32'(stable), 32'd1);
        wait_busy(1'b0, 500, "stall finish");
        check_str("stall output", cap, {"100", p2_txt, "7", reply("000E", "0002"), p1_txt});

        // Asynchronous reset while a prompt byte is on offer.
        send_line("5", 1'b0, "mid-prompt");
        check("mid-prompt tx_valid", 32'(tx_valid), 32'd1);
        reset_and_init("mid-prompt");

        // Reset on the fifth DIVIDE cycle.
        send_line("100", 1'b1, "mid-divide a");
        send_byte("7");
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_byte  = 8'h0D;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("mid-divide busy", 32'(busy), 32'd1);
        reset_and_init("mid-divide");

        run_vec(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
